// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbitration slice.
// Imported by the arbiter and its round-robin helper.
package alu_pkg;

    localparam int DEF_BW = 16;

    localparam int FLAG_OVF  = 2;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_ZERO = 0;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last winner
// and wraps, returning a one-hot grant plus its index.
module rr_arbiter
    import alu_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            for (int j = 0; j < NREQ; j++) begin
                if (!any && (j == idx) && req[j]) begin
                    any     = 1'b1;
                    gnt[j]  = 1'b1;
                    gnt_idx = IDW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Time-shares one external ALU between NREQ requesters: grant, execute
// from registered operands, then hold a tagged response until taken.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int BW   = DEF_BW,
    parameter  int NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0][BW-1:0]   req_a,
    input  logic [NREQ-1:0][BW-1:0]   req_b,
    input  logic [NREQ-1:0][3:0]      req_op,
    output logic [BW-1:0]             alu_a,
    output logic [BW-1:0]             alu_b,
    output logic [3:0]                alu_op,
    input  logic [BW-1:0]             alu_out,
    input  logic [2:0]                alu_flags,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic [BW-1:0]             rsp_out,
    output logic [2:0]                rsp_flags
);

    arb_state_t     state_q;
    logic [BW-1:0]  a_q;
    logic [BW-1:0]  b_q;
    logic [3:0]     op_q;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] last_q;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [BW-1:0]  rsp_out_q;
    logic [2:0]     rsp_flags_q;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req     (req_valid),
        .last    (last_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    // Ready is a pure function of state and winner; reset masks it at once.
    assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_flags = rsp_flags_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= '0;
            last_q      <= IDW'(NREQ - 1);
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_out_q   <= '0;
            rsp_flags_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        a_q     <= req_a[gnt_idx];
                        b_q     <= req_b[gnt_idx];
                        op_q    <= req_op[gnt_idx];
                        id_q    <= gnt_idx;
                        last_q  <= gnt_idx;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_out_q   <= alu_out;
                    rsp_flags_q <= alu_flags;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a 2-requester instance for the main
// flows and a 3-requester instance for wrap-around.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 2-requester instance
    logic [1:0]       v2 = '0;
    logic [1:0]       rdy2;
    logic [1:0][15:0] a2 = '0;
    logic [1:0][15:0] b2 = '0;
    logic [1:0][3:0]  op2 = '0;
    logic [15:0]      aa2, ab2, ao2;
    logic [3:0]       aop2;
    logic [2:0]       af2;
    logic             rv2;
    logic             rr2 = 1'b1;
    logic [0:0]       rid2;
    logic [15:0]      rout2;
    logic [2:0]       rfl2;

    // 3-requester instance
    logic [2:0]       v3 = '0;
    logic [2:0]       rdy3;
    logic [2:0][15:0] a3 = '0;
    logic [2:0][15:0] b3 = '0;
    logic [2:0][3:0]  op3 = '0;
    logic [15:0]      aa3, ab3, ao3;
    logic [3:0]       aop3;
    logic [2:0]       af3;
    logic             rv3;
    logic             rr3 = 1'b1;
    logic [1:0]       rid3;
    logic [15:0]      rout3;
    logic [2:0]       rfl3;

    alu_arbiter #(.BW(16), .NREQ(2)) u2 (
        .clk(clk), .rst(rst),
        .req_valid(v2), .req_ready(rdy2),
        .req_a(a2), .req_b(b2), .req_op(op2),
        .alu_a(aa2), .alu_b(ab2), .alu_op(aop2),
        .alu_out(ao2), .alu_flags(af2),
        .rsp_valid(rv2), .rsp_ready(rr2),
        .rsp_id(rid2), .rsp_out(rout2), .rsp_flags(rfl2)
    );

    alu_arbiter #(.BW(16), .NREQ(3)) u3 (
        .clk(clk), .rst(rst),
        .req_valid(v3), .req_ready(rdy3),
        .req_a(a3), .req_b(b3), .req_op(op3),
        .alu_a(aa3), .alu_b(ab3), .alu_op(aop3),
        .alu_out(ao3), .alu_flags(af3),
        .rsp_valid(rv3), .rsp_ready(rr3),
        .rsp_id(rid3), .rsp_out(rout3), .rsp_flags(rfl3)
    );

    // ALU model: op 0 add, otherwise subtract; flags {ovf, neg, zero}
    function automatic logic [18:0] alu_m(
        input logic [15:0] a, input logic [15:0] b, input logic [3:0] op
    );
        logic [15:0] r;
        logic        ovf;
        if (op == 4'd0) begin
            r   = a + b;
            ovf = (a[15] == b[15]) && (r[15] != a[15]);
        end else begin
            r   = a - b;
            ovf = (a[15] != b[15]) && (r[15] != a[15]);
        end
        return {ovf, r[15], (r == 16'd0), r};
    endfunction

    assign {af2, ao2} = alu_m(aa2, ab2, aop2);
    assign {af3, ao3} = alu_m(aa3, ab3, aop3);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_rv", 32'(rv2), 32'd0);
        chk("rst_rdy", 32'(rdy2), 32'd0);
        chk("rst_alu_a", 32'(aa2), 32'd0);
        chk("rst_alu_op", 32'(aop2), 32'd0);
        chk("rst_rout", 32'(rout2), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // single request: 5 + 3
        v2 = 2'b01; a2[0] = 16'd5; b2[0] = 16'd3; op2[0] = 4'd0; rr2 = 1'b1;
        #1;
        chk("single_rdy_T", 32'(rdy2), 32'b01);
        tick();
        v2 = 2'b00;
        #1;
        chk("single_rv_T1", 32'(rv2), 32'd0);
        chk("single_alu_a", 32'(aa2), 32'd5);
        chk("single_alu_b", 32'(ab2), 32'd3);
        tick();
        chk("single_rv_T2", 32'(rv2), 32'd1);
        chk("single_id", 32'(rid2), 32'd0);
        chk("single_out", 32'(rout2), 32'd8);
        chk("single_flags", 32'(rfl2), 32'b000);
        tick();
        chk("single_idle", 32'(rv2), 32'd0);

        // backpressure: requester 1, 100 + 50
        v2 = 2'b10; a2[1] = 16'd100; b2[1] = 16'd50; op2[1] = 4'd0; rr2 = 1'b0;
        #1;
        chk("bp_rdy", 32'(rdy2), 32'b10);
        tick();
        v2 = 2'b11;
        #1;
        chk("bp_exec_rdy", 32'(rdy2), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_rv", 32'(rv2), 32'd1);
            chk("bp_hold_id", 32'(rid2), 32'd1);
            chk("bp_hold_out", 32'(rout2), 32'd150);
            chk("bp_hold_flags", 32'(rfl2), 32'b000);
            chk("bp_hold_rdy", 32'(rdy2), 32'd0);
            if (i < 4) tick();
        end
        rr2 = 1'b1;
        #1;
        chk("bp_release_rv", 32'(rv2), 32'd1);
        tick();
        chk("bp_idle_rv", 32'(rv2), 32'd0);
        chk("bp_idle_rdy", 32'(rdy2), 32'b01);
        v2 = 2'b00;
        #1;

        // overflow flags on requester 0, then reset while in RESP
        v2 = 2'b01; a2[0] = 16'h7FFF; b2[0] = 16'd1; rr2 = 1'b0;
        tick();
        v2 = 2'b00;
        tick();
        chk("ovf_rv", 32'(rv2), 32'd1);
        chk("ovf_out", 32'(rout2), 32'h8000);
        chk("ovf_flags", 32'(rfl2), 32'b110);
        v2 = 2'b11;
        rst = 1'b1;
        #1;
        chk("rmid_rv", 32'(rv2), 32'd0);
        chk("rmid_out", 32'(rout2), 32'd0);
        chk("rmid_flags", 32'(rfl2), 32'd0);
        chk("rmid_rdy", 32'(rdy2), 32'd0);
        chk("rmid_alu_a", 32'(aa2), 32'd0);
        tick();
        chk("rmid_rdy_hold", 32'(rdy2), 32'd0);
        rst = 1'b0;
        v2 = 2'b10; a2[1] = 16'hFFFC; b2[1] = 16'd4;
        #1;
        chk("rmid_grant1", 32'(rdy2), 32'b10);
        tick();
        v2 = 2'b00; rr2 = 1'b1;
        tick();
        chk("zero_id", 32'(rid2), 32'd1);
        chk("zero_out", 32'(rout2), 32'd0);
        chk("zero_flags", 32'(rfl2), 32'b001);
        tick();

        // fairness: both valid, expect 0,1,0,1 at one per 3 cycles
        v2 = 2'b11;
        a2[0] = 16'd1;  b2[0] = 16'd2;
        a2[1] = 16'd10; b2[1] = 16'd20;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("fair_rdy", 32'(rdy2), (i % 2 == 0) ? 32'b01 : 32'b10);
            tick();
            chk("fair_exec_rv", 32'(rv2), 32'd0);
            tick();
            chk("fair_rv", 32'(rv2), 32'd1);
            chk("fair_id", 32'(rid2), 32'(i % 2));
            chk("fair_out", 32'(rout2), (i % 2 == 0) ? 32'd3 : 32'd30);
            tick();
        end
        v2 = 2'b00;

        // wrap-around on the 3-requester instance
        v3 = 3'b100; a3[2] = 16'd9; b3[2] = 16'd1; rr3 = 1'b1;
        #1;
        chk("wrap_first", 32'(rdy3), 32'b100);
        tick();
        v3 = 3'b000;
        tick();
        chk("wrap_id2", 32'(rid3), 32'd2);
        chk("wrap_out2", 32'(rout3), 32'd10);
        tick();
        v3 = 3'b101; a3[0] = 16'd4; b3[0] = 16'd4;
        #1;
        chk("wrap_rdy0", 32'(rdy3), 32'b001);
        tick();
        tick();
        chk("wrap_id0", 32'(rid3), 32'd0);
        chk("wrap_out0", 32'(rout3), 32'd8);
        tick();
        chk("wrap_next2", 32'(rdy3), 32'b100);
        v3 = 3'b000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` instance between `NREQ` requesters. Each requester offers an operation over a valid/ready handshake. The block grants one requester per operation in round-robin order and drives the shared ALU from registered operands. It returns the registered result and flags, tagged with the requester index, over a single valid/ready response channel. It sits between the requesting units and the `alu`; the `alu` itself is instantiated by the parent and connected through the `alu_*` ports.

## Interface
- `BW`, 16, operand/result bitwidth (matches `alu` `BW`)
- `NREQ`, 2, number of requesters (2..8)
- `IDW`, `$clog2(NREQ)`, requester-index width (localparam)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  NREQ  per-requester operation valid
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero
- `req_a`  in  NREQ×BW  signed operand A per requester (packed array)
- `req_b`  in  NREQ×BW  signed operand B per requester
- `req_op`  in  NREQ×4  ALU opcode per requester
- `alu_a`, `alu_b`  out  BW  operands to shared ALU
- `alu_op`  out  4  opcode to shared ALU
- `alu_out`  in  BW  ALU result
- `alu_flags`  in  3  ALU `{overflow, negative, zero}`
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumer ready
- `rsp_id`  out  IDW  index of requester that issued the operation
- `rsp_out`  out  BW  captured result
- `rsp_flags`  out  3  captured `{overflow, negative, zero}`

## Operation
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE:**
  - `req_ready[g]=1` combinationally for the round-robin winner `g` among the asserted `req_valid` bits.
  - On the handshake, latch `req_a[g]`, `req_b[g]`, `req_op[g]` and `g` into operand registers, set `last_grant=g`, and go to EXEC.
  - If no `req_valid` is asserted, stay in IDLE.
- **Round-robin rule:**
  - Search starts at `(last_grant+1) mod NREQ` and wraps.
  - `last_grant` resets to `NREQ-1`, so requester 0 wins first.
  - `last_grant` updates only on an accepted handshake.
- **EXEC:**
  - `alu_a`/`alu_b`/`alu_op` show the operand registers; they always do, in every state.
  - Capture `alu_out` and `alu_flags` into `rsp_out` and `rsp_flags`, copy the latched id to `rsp_id`, and go to RESP.
- **RESP:**
  - `rsp_valid=1`.
  - `rsp_id`, `rsp_out` and `rsp_flags` stay stable until `rsp_ready` is sampled high.
  - Then go to IDLE.
- **Outside IDLE:** `req_ready` is all zero.
- **Requester rule:** a requester must hold `req_valid` and its operands stable until `req_ready`. The block does not check this.
- **Pass-through:** the ALU is not inspected; opcodes and flags are passed through unmodified.

## Timing
- **Reset values** (immediately on `rst` asserted, asynchronously):
  - state IDLE
  - `req_ready=0` (forced while `rst` is high)
  - `rsp_valid=0`, `rsp_id=0`, `rsp_out=0`, `rsp_flags=0`
  - operand registers 0, so `alu_a=0`, `alu_b=0`, `alu_op=0`
  - `last_grant=NREQ-1`
- **Latency:** handshake in cycle T, ALU evaluated in cycle T+1, `rsp_valid` high from cycle T+2.
- **Throughput:** best case one operation per 3 cycles, with `rsp_ready` held high.
- **Backpressure:** `rsp_ready` low holds RESP indefinitely. No new request is accepted meanwhile.
- **`rsp_ready` outside RESP:** ignored.
- **Reset mid-operation** (EXEC or RESP): the in-flight operation is dropped with no response, and arbitration restarts at requester 0.
- **A `req_valid` dropped in IDLE before grant:** no effect.

## Structure
- **Package `alu_pkg`:**
  - default `BW`
  - flag index constants `FLAG_OVF=2`, `FLAG_NEG=1`, `FLAG_ZERO=0`
  - `typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t`
- **Sub-module `rr_arbiter`** (parameter `NREQ`):
  - inputs `req[NREQ-1:0]`, `last[IDW-1:0]`
  - outputs one-hot `gnt`, `gnt_idx`, `any`
  - purely combinational
- **`alu_arbiter`:** holds the FSM, operand/response registers and `last_grant`.

## Test plan
The bench models the ALU with opcode 0 = add, computing flags as `alu` does.

- **Reset mid-RESP.** Assert `rst` while `rsp_valid=1`. Required: `rsp_valid`, `rsp_out`, `rsp_flags` and `req_ready` read 0 in the same cycle. The next `req_valid[1]` alone is granted.
- **Single request.** `req_valid[0]` with a=5, b=3, op=0, `rsp_ready=1`. Required: `req_ready[0]` in cycle T; `rsp_valid` in cycle T+2 with `rsp_id=0`, `rsp_out=8`, `rsp_flags=3'b000`.
- **Fairness.** Both requesters valid continuously, `rsp_ready=1`. Required: grant order 0,1,0,1; `rsp_id` alternates; one response every 3 cycles.
- **Backpressure.** `rsp_ready=0` for 5 cycles during RESP. Required: response fields stable and `req_ready=0` throughout; release takes effect on the first high sample, and IDLE is re-entered the next cycle.
- **Flags.** a=16'h7FFF, b=1, op=0. Required: `rsp_out=16'h8000`, `rsp_flags=3'b110`.
- **Flags.** a=-4, b=4, op=0. Required: `rsp_out=0`, `rsp_flags=3'b001`.
- **Wrap-around.** `NREQ=3`, after requester 2 is granted, requesters 0 and 2 are valid. Required: requester 0 wins.
